key_latch_debouncer: RTL

Upstream front end for the 10-switch to 32-bit word loader on the DE10 board. Takes a raw active-low pushbutton (KEY) and the 10 raw slide switches, synchronizes and debounces them, and produces a clean one-cycle `latch` pulse. It presents a stable switch value that is set up one cycle before `latch` rises. It also tracks which of the four byte lanes have been loaded, so the user can see when a full 32-bit word is entered.

---
 rtl/key_latch_debouncer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/key_latch_debouncer.sv
// Pushbutton/switch front end for the DE10 word loader: synchronizes and debounces
// KEY, captures the switches once per accepted press, and tracks the loaded byte lanes.
module key_latch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SW_WIDTH        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_n,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                latch,
  output logic                pressed,
  output logic [3:0]          lane_loaded,
  output logic                all_loaded
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                pend, pend_d;
  logic                latch_d, pressed_d, all_loaded_d;
  logic [SW_WIDTH-1:0] sw_out_d;
  logic [3:0]          lane_d, lane_onehot;
  logic [1:0]          lane_sel;

  logic                k1, ks;
  logic [SW_WIDTH-1:0] s1, ss;

  // Two-flop synchronizers; key resets to released
  always_ff @(posedge clk) begin
    if (reset) begin
      k1 <= 1'b1;
      ks <= 1'b1;
      s1 <= '0;
      ss <= '0;
    end else begin
      k1 <= key_n;
      ks <= k1;
      s1 <= sw;
      ss <= s1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      latch       <= 1'b0;
      pressed     <= 1'b0;
      sw_out      <= '0;
      lane_loaded <= 4'h0;
      all_loaded  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pend        <= pend_d;
      latch       <= latch_d;
      pressed     <= pressed_d;
      sw_out      <= sw_out_d;
      lane_loaded <= lane_d;
      all_loaded  <= all_loaded_d;
    end
  end

  assign lane_sel    = sw_out[SW_WIDTH-1 -: 2];
  assign lane_onehot = 4'b0001 << lane_sel;

  // Next-state logic; pend delays latch one cycle behind the sw_out capture
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_d    = 1'b0;
    latch_d   = pend;
    pressed_d = pressed;
    sw_out_d  = sw_out;
    lane_d    = lane_loaded;

    case (state)
      IDLE: begin
        if (!ks) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (ks) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d   = HELD;
          cnt_d     = '0;
          sw_out_d  = ss;
          pend_d    = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (ks) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!ks) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A latch after a full word starts the next word
    if (pend) begin
      lane_d = (lane_loaded == 4'hF) ? lane_onehot : (lane_loaded | lane_onehot);
    end

    all_loaded_d = &lane_d;
  end

endmodule
